in_port_capture: RTL and testbench
==================================

Name: in_port_capture

Overview:
- Upstream capture stage for one input-bus source. Each instance drives one of the 16 8-bit inputs of the CPU's input-port multiplexer.
- It takes a byte from an asynchronous external peripheral using a 4-phase strobe/ack handshake and synchronises the strobe into the CPU clock domain.
- It holds the byte stable for the multiplexer and raises a full flag. The flag clears when the CPU reads this port's address.
- While full, the block stalls the peripheral (withholds ack), so data is never lost.

Parameters:
- WIDTH, 8, data width of captured byte and data_out.
- SYNC_STAGES, 2, flops in the ext_strobe synchroniser; legal range 2..4.
- PORT_ADDR, 4'd0, input-bus address this instance answers to; compared against rd_addr.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ext_data  in  WIDTH  peripheral data; must be stable from before ext_strobe rises until ext_ack is seen high.
- ext_strobe  in  1  asynchronous peripheral request, 4-phase.
- ext_ack  out  1  registered acknowledge to peripheral.
- rd_en  in  1  CPU input-bus read enable (same signal as the mux enable).
- rd_addr  in  4  CPU input-bus address (same signal as the mux select).
- data_out  out  WIDTH  held captured byte; wires to the mux input for PORT_ADDR.
- full  out  1  captured byte not yet read by CPU.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset (asserted at any time, including mid-handshake):
  - synchroniser flops=0, state=IDLE, ext_ack=0, full=0, data_out=0.
  - The peripheral must restart its handshake after reset.
- Synchroniser: s_strobe = output of a SYNC_STAGES-deep flop chain on ext_strobe. The FSM uses s_strobe only. ext_data is sampled unsynchronised; protocol guarantees stability.
- rd_hit = rd_en && (rd_addr == PORT_ADDR), sampled at the clk edge.
- FSM states: IDLE, HOLD, ACK.
  - IDLE (ext_ack=0):
    - s_strobe=1 and full=0 -> data_out<=ext_data, full<=1, ext_ack<=1, go ACK.
    - s_strobe=1 and full=1 -> go HOLD.
    - otherwise stay.
  - HOLD (ext_ack=0): full=0 -> capture exactly as in IDLE, go ACK; otherwise stay.
  - ACK (ext_ack=1): s_strobe=0 -> ext_ack<=0, go IDLE; otherwise stay.
  - A second capture requires a full strobe low->high cycle.
- full flag:
  - Set on capture. Cleared on rd_hit.
  - Capture and rd_hit on the same edge -> set wins, full=1; the read consumed the old byte.
  - The FSM tests the pre-edge value of full. In HOLD, an rd_hit edge clears full and the capture occurs on the following edge.
  - rd_hit while full=0 -> no effect.
- data_out changes only on capture. It is unaffected by reads and holds its value indefinitely.
- Latency (SYNC_STAGES=2):
  - ext_strobe high before edge E0 -> capture and ext_ack=1 after edge E2.
  - ext_strobe low before edge E(n) -> ext_ack=0 after edge E(n+2).
  - General latency is SYNC_STAGES edges to s_strobe, plus one edge to FSM action.
- ext_strobe dropping while in HOLD (protocol violation) -> return to IDLE on next edge, no capture, full unchanged.
- rd_addr matching another port -> no effect on this instance.

Test Plan:
- Reset: hold rst_n=0 with ext_strobe=1 and rd_en=1 -> ext_ack=0, full=0, data_out=8'h00. Release reset -> capture follows after 3 edges.
- Basic handshake: ext_data=8'hA5, raise ext_strobe -> after 3 edges data_out=8'hA5, full=1, ext_ack=1. Drop strobe -> ext_ack=0 after 3 edges.
- CPU read clear: full=1, pulse rd_en=1 with rd_addr=PORT_ADDR for one cycle -> full=0 next edge, data_out still 8'hA5. rd_addr=PORT_ADDR+1 -> full stays 1.
- Backpressure: full=1, peripheral strobes ext_data=8'h3C -> FSM in HOLD, ext_ack stays 0, data_out=8'hA5. Issue rd_hit at edge N -> full=0 at N; capture of 8'h3C and ext_ack=1 at N+1.
- Simultaneous: full=0 with capture of 8'h77 and rd_hit on the same edge -> full=1, data_out=8'h77.
- Mid-handshake reset: assert rst_n=0 while in ACK -> ext_ack drops immediately without a clock edge, full=0, data_out=0.

Source files
------------

// File: rtl/in_port_capture_if.sv
// Peripheral and CPU input-bus signals for one capture port.
// The master drives the peripheral and CPU side; the slave is the capture block.
interface in_port_capture_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] ext_data;
    logic             ext_strobe;
    logic             ext_ack;
    logic             rd_en;
    logic [3:0]       rd_addr;
    logic [WIDTH-1:0] data_out;
    logic             full;

    modport master (
        output ext_data,
        output ext_strobe,
        input  ext_ack,
        output rd_en,
        output rd_addr,
        input  data_out,
        input  full
    );

    modport slave (
        input  ext_data,
        input  ext_strobe,
        output ext_ack,
        input  rd_en,
        input  rd_addr,
        output data_out,
        output full
    );
endinterface

// File: rtl/in_port_capture.sv
// Captures a byte from an asynchronous 4-phase strobe/ack peripheral
// and holds it for the CPU input-port mux until this port is read.
module in_port_capture #(
    parameter int         WIDTH       = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] PORT_ADDR   = 4'd0
) (
    input logic               clk,
    input logic               rst_n,
    in_port_capture_if.slave  bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_strobe;
    logic                   rd_hit;
    logic                   capture;
    logic                   ack_q;
    logic                   ack_d;
    logic                   full_q;
    logic                   full_d;
    logic [WIDTH-1:0]       data_q;

    assign s_strobe = sync_q[SYNC_STAGES-1];
    assign rd_hit   = bus.rd_en && (bus.rd_addr == PORT_ADDR);

    // Bring the asynchronous strobe into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ext_strobe};
        end
    end

    // Handshake FSM: decides when to capture and when to ack.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_strobe) begin
                    if (!full_q) begin
                        capture = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Strobe withdrawn while stalled: abandon without capture.
                if (!s_strobe) begin
                    state_d = IDLE;
                end else if (!full_q) begin
                    capture = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!s_strobe) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Capture wins over a same-edge read: the read took the old byte.
    always_comb begin
        full_d = full_q;
        if (capture) begin
            full_d = 1'b1;
        end else if (rd_hit) begin
            full_d = 1'b0;
        end
    end

    // State, ack, flag and held byte registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            full_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            full_q  <= full_d;
            if (capture) begin
                data_q <= bus.ext_data;
            end
        end
    end

    assign bus.ext_ack  = ack_q;
    assign bus.full     = full_q;
    assign bus.data_out = data_q;

endmodule

// File: tb/tb_in_port_capture.sv
// Directed bench for in_port_capture with a scoreboard of expected bytes.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_in_port_capture;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    logic [7:0] sb_q[$];

    in_port_capture_if #(.WIDTH(8)) bus ();

    in_port_capture #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .PORT_ADDR(4'd0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the next expected byte and compare against the held output.
    task automatic sb_check(input string tag);
        logic [7:0] e;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: observed capture, expected none queued", tag);
        end else begin
            e = sb_q.pop_front();
            chk(tag, {24'd0, bus.data_out}, {24'd0, e});
        end
    endtask

    task automatic send(input logic [7:0] d);
        bus.ext_data   = d;
        bus.ext_strobe = 1'b1;
        sb_q.push_back(d);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // Reset with strobe and read active.
        rst_n          = 1'b0;
        bus.ext_data   = 8'h11;
        bus.ext_strobe = 1'b1;
        bus.rd_en      = 1'b1;
        bus.rd_addr    = 4'd0;
        tick(2);
        chk("rst_ack", bus.ext_ack, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_data", bus.data_out, 8'h00);
        bus.rd_en = 1'b0;
        sb_q.push_back(8'h11);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_ack_early", bus.ext_ack, 0);
        chk("post_rst_full_early", bus.full, 0);
        tick(1);
        chk("post_rst_ack", bus.ext_ack, 1);
        chk("post_rst_full", bus.full, 1);
        sb_check("post_rst_data");
        bus.ext_strobe = 1'b0;
        tick(3);
        chk("post_rst_ack_drop", bus.ext_ack, 0);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        chk("post_rst_clear", bus.full, 0);

        // Basic handshake.
        send(8'hA5);
        tick(2);
        chk("basic_ack_early", bus.ext_ack, 0);
        tick(1);
        chk("basic_ack", bus.ext_ack, 1);
        chk("basic_full", bus.full, 1);
        sb_check("basic_data");
        bus.ext_strobe = 1'b0;
        tick(2);
        chk("basic_ack_hold", bus.ext_ack, 1);
        tick(1);
        chk("basic_ack_drop", bus.ext_ack, 0);

        // Read of another address leaves the flag alone.
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd1;
        tick(1);
        bus.rd_en = 1'b0;
        chk("other_addr_full", bus.full, 1);

        // Backpressure: strobe while full stalls in HOLD.
        send(8'h3C);
        tick(5);
        chk("bp_ack", bus.ext_ack, 0);
        chk("bp_full", bus.full, 1);
        chk("bp_data", bus.data_out, 8'hA5);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd0;
        tick(1);
        bus.rd_en = 1'b0;
        chk("bp_read_full", bus.full, 0);
        chk("bp_read_ack", bus.ext_ack, 0);
        chk("bp_read_data", bus.data_out, 8'hA5);
        tick(1);
        chk("bp_cap_ack", bus.ext_ack, 1);
        chk("bp_cap_full", bus.full, 1);
        sb_check("bp_cap_data");
        bus.ext_strobe = 1'b0;
        tick(3);
        chk("bp_ack_drop", bus.ext_ack, 0);

        // Strobe withdrawn while stalled: no capture.
        bus.ext_data   = 8'h99;
        bus.ext_strobe = 1'b1;
        tick(3);
        bus.ext_strobe = 1'b0;
        tick(4);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        chk("abort_full", bus.full, 0);
        tick(4);
        chk("abort_ack", bus.ext_ack, 0);
        chk("abort_full_stays", bus.full, 0);
        chk("abort_data", bus.data_out, 8'h3C);

        // Read while empty has no effect.
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        chk("empty_read_full", bus.full, 0);

        // Capture and read on the same edge: set wins.
        send(8'h77);
        tick(2);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd0;
        tick(1);
        bus.rd_en = 1'b0;
        chk("simul_full", bus.full, 1);
        chk("simul_ack", bus.ext_ack, 1);
        sb_check("simul_data");

        // Reset mid-handshake acts without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", bus.ext_ack, 0);
        chk("midrst_full", bus.full, 0);
        chk("midrst_data", bus.data_out, 8'h00);
        bus.ext_strobe = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(4);
        chk("after_midrst_ack", bus.ext_ack, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
